// File: rtl/mem_stage_sram_pkg.sv
// Shared types and widths for the MEM stage with 16-bit external SRAM.
package mem_stage_sram_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;
   localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;
   localparam int MEM_WORD_W  = 2 * SRAM_DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM sequencer: splits one 32-bit access into low/high 16-bit halves,
// each held for SRAM_WAIT cycles, and assembles read data into mem_data.
//
// state | meaning
// IDLE  | waiting for a memory request; latches index, store value, op type
// LOW   | low half-word access, addr LSB = 0
// HIGH  | high half-word access, addr LSB = 1
// DONE  | one-cycle result window, mem_data valid
module sram_ctrl
   import mem_stage_sram_pkg::*;
#(
   parameter int SRAM_WAIT = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_req,
   input  logic                   wr_req,
   input  logic [WORD_IDX_W-1:0]  word_index_in,
   input  logic [MEM_WORD_W-1:0]  wr_data_in,
   output sram_state_t            state,
   output logic [MEM_WORD_W-1:0]  mem_data,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
);

   localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

   sram_state_t             state_q;
   sram_state_t             state_d;
   logic [3:0]              wait_cnt;
   logic                    wait_tc;
   logic                    req;
   logic [WORD_IDX_W-1:0]   word_index;
   logic [MEM_WORD_W-1:0]   st_val;
   logic                    op_write;

   assign req     = rd_req | wr_req;
   assign wait_tc = (wait_cnt == 4'd0);
   assign state   = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = LOW;
         LOW:     if (wait_tc) state_d = HIGH;
         HIGH:    if (wait_tc) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write wins when both enables are set, so a read sample is suppressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt   <= '0;
         word_index <= '0;
         st_val     <= '0;
         op_write   <= 1'b0;
         mem_data   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  wait_cnt   <= WAIT_LOAD;
                  word_index <= word_index_in;
                  st_val     <= wr_data_in;
                  op_write   <= wr_req;
               end
            end
            LOW: begin
               if (wait_tc) begin
                  wait_cnt <= WAIT_LOAD;
                  if (!op_write) mem_data[SRAM_DATA_W-1:0] <= sram_dq_in;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            HIGH: begin
               if (wait_tc) begin
                  if (!op_write) mem_data[MEM_WORD_W-1:SRAM_DATA_W] <= sram_dq_in;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = '0;
      sram_addr   = {word_index, (state_q == HIGH)};
      if ((state_q == LOW) || (state_q == HIGH)) begin
         if (op_write) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = (state_q == HIGH) ? st_val[MEM_WORD_W-1:SRAM_DATA_W]
                                            : st_val[SRAM_DATA_W-1:0];
         end else begin
            sram_oe_n = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: pass-through of EXE controls plus stall generation
// around the SRAM sequencer. Optional stall counter under MEM_STAGE_STALL_CNT_EN.
module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int SRAM_WAIT = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   WB_En_in,
   input  logic                   MEM_R_En_in,
   input  logic                   MEM_W_En_in,
   input  logic [4:0]             dest_in,
   input  logic [31:0]            PC_in,
   input  logic [31:0]            ALU_result_in,
   input  logic [31:0]            ST_val_in,
   output logic                   WB_En,
   output logic                   MEM_R_En,
   output logic [4:0]             dest,
   output logic [31:0]            PC,
   output logic [31:0]            ALU_result,
   output logic [31:0]            Mem_Data,
   output logic                   stall,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
   input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
   output logic                   SRAM_DQ_oe,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N
`ifdef MEM_STAGE_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   sram_state_t state;

   assign WB_En      = WB_En_in;
   assign MEM_R_En   = MEM_R_En_in;
   assign dest       = dest_in;
   assign PC         = PC_in;
   assign ALU_result = ALU_result_in;

   sram_ctrl #(
      .SRAM_WAIT (SRAM_WAIT)
   ) u_sram_ctrl (
      .clk           (clk),
      .rst           (rst),
      .rd_req        (MEM_R_En_in),
      .wr_req        (MEM_W_En_in),
      .word_index_in (ALU_result_in[18:2]),
      .wr_data_in    (ST_val_in),
      .state         (state),
      .mem_data      (Mem_Data),
      .sram_addr     (SRAM_ADDR),
      .sram_dq_out   (SRAM_DQ_out),
      .sram_dq_in    (SRAM_DQ_in),
      .sram_dq_oe    (SRAM_DQ_oe),
      .sram_we_n     (SRAM_WE_N),
      .sram_oe_n     (SRAM_OE_N)
   );

   // Stalling in IDLE on a live request holds the pipeline for the latch cycle.
   assign stall = ((state == IDLE) && (MEM_R_En_in || MEM_W_En_in)) ||
                  (state == LOW) || (state == HIGH);

`ifdef MEM_STAGE_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a small behavioural SRAM model.
module tb_mem_stage_sram;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_En_in, MEM_R_En_in, MEM_W_En_in;
   logic [4:0]  dest_in;
   logic [31:0] PC_in, ALU_result_in, ST_val_in;
   logic        WB_En, MEM_R_En;
   logic [4:0]  dest;
   logic [31:0] PC, ALU_result, Mem_Data;
   logic        stall;
   logic [17:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
   logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;
`ifdef MEM_STAGE_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] cnt_before;
`endif

   logic [15:0] mem [0:1023];
   logic [17:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   logic        wr_oe_q[$];
   int          rd_cycles;
   int          strobes;
   int          n_checks = 0;
   int          n_pass = 0;
   int          nstall;
   logic [31:0] md;

   always #5 clk = ~clk;

   mem_stage_sram #(.SRAM_WAIT(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .WB_En_in      (WB_En_in),
      .MEM_R_En_in   (MEM_R_En_in),
      .MEM_W_En_in   (MEM_W_En_in),
      .dest_in       (dest_in),
      .PC_in         (PC_in),
      .ALU_result_in (ALU_result_in),
      .ST_val_in     (ST_val_in),
      .WB_En         (WB_En),
      .MEM_R_En      (MEM_R_En),
      .dest          (dest),
      .PC            (PC),
      .ALU_result    (ALU_result),
      .Mem_Data      (Mem_Data),
      .stall         (stall),
      .SRAM_ADDR     (SRAM_ADDR),
      .SRAM_DQ_out   (SRAM_DQ_out),
      .SRAM_DQ_in    (SRAM_DQ_in),
      .SRAM_DQ_oe    (SRAM_DQ_oe),
      .SRAM_WE_N     (SRAM_WE_N),
      .SRAM_OE_N     (SRAM_OE_N)
`ifdef MEM_STAGE_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   assign SRAM_DQ_in = SRAM_OE_N ? 16'h0000 : mem[SRAM_ADDR[9:0]];

   always @(negedge clk) begin
      if (!SRAM_WE_N) begin
         mem[SRAM_ADDR[9:0]] = SRAM_DQ_out;
         wr_addr_q.push_back(SRAM_ADDR);
         wr_data_q.push_back(SRAM_DQ_out);
         wr_oe_q.push_back(SRAM_DQ_oe);
      end
      if (!SRAM_OE_N) rd_cycles = rd_cycles + 1;
      if (!SRAM_WE_N || !SRAM_OE_N) strobes = strobes + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_oe_q.delete();
      rd_cycles = 0;
      strobes = 0;
   endtask

   // Issues one request in IDLE, scrambles the inputs once the access is in
   // flight, and returns the stall length and Mem_Data seen in the DONE cycle.
   task automatic do_op(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] st, output int ns, output logic [31:0] mdo);
      logic done;
      done = 1'b0;
      ns = 0;
      mdo = '0;
      @(posedge clk);
      #1;
      MEM_R_En_in = rd;
      MEM_W_En_in = wr;
      ALU_result_in = alu;
      ST_val_in = st;
      for (int i = 0; i < 64 && !done; i++) begin
         #1;
         if (stall) begin
            ns++;
            @(posedge clk);
            #1;
            if (ns == 2) begin
               ALU_result_in = 32'h0007_FFFC;
               ST_val_in = 32'h5555_AAAA;
            end
         end else begin
            mdo = Mem_Data;
            done = 1'b1;
         end
      end
      MEM_R_En_in = 1'b0;
      MEM_W_En_in = 1'b0;
      check("op_timeout", 64'(done), 64'(1));
   endtask

   initial begin
      rst = 1'b1;
      WB_En_in = 1'b0;
      MEM_R_En_in = 1'b0;
      MEM_W_En_in = 1'b0;
      dest_in = '0;
      PC_in = '0;
      ALU_result_in = '0;
      ST_val_in = '0;
      clear_logs();
      #2;
      check("rst_stall", 64'(stall), 64'(0));
      check("rst_we_n", 64'(SRAM_WE_N), 64'(1));
      check("rst_oe_n", 64'(SRAM_OE_N), 64'(1));
      check("rst_dq_oe", 64'(SRAM_DQ_oe), 64'(0));
      check("rst_mem_data", 64'(Mem_Data), 64'(0));
`ifdef MEM_STAGE_STALL_CNT_EN
      check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Non-memory instruction: pure pass-through, no stall, no strobes
      clear_logs();
      WB_En_in = 1'b1;
      dest_in = 5'h13;
      PC_in = 32'h0000_1234;
      ALU_result_in = 32'h0000_0404;
      ST_val_in = 32'hAAAA_5555;
      #1;
      check("pt_wb_en", 64'(WB_En), 64'(1));
      check("pt_mem_r_en", 64'(MEM_R_En), 64'(0));
      check("pt_dest", 64'(dest), 64'(5'h13));
      check("pt_pc", 64'(PC), 64'(32'h0000_1234));
      check("pt_alu", 64'(ALU_result), 64'(32'h0000_0404));
      check("nomem_stall", 64'(stall), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("nomem_strobes", 64'(strobes), 64'(0));
      check("nomem_stall_late", 64'(stall), 64'(0));
      WB_En_in = 1'b0;

      // Write 0xDEADBEEF to byte address 0x404 -> half addrs 0x202/0x203
      clear_logs();
      do_op(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, nstall, md);
      check("wr_stall_len", 64'(nstall), 64'(2 * W + 1));
      check("wr_mem_data", 64'(md), 64'(0));
      check("wr_beats", 64'(wr_addr_q.size()), 64'(2 * W));
      check("wr_rd_cycles", 64'(rd_cycles), 64'(0));
      for (int i = 0; i < wr_addr_q.size() && i < 2 * W; i++) begin
         check("wr_addr", 64'(wr_addr_q[i]), (i < W) ? 64'(18'h00202) : 64'(18'h00203));
         check("wr_data", 64'(wr_data_q[i]), (i < W) ? 64'(16'hBEEF) : 64'(16'hDEAD));
         check("wr_dq_oe", 64'(wr_oe_q[i]), 64'(1));
      end

      // Read it back
      clear_logs();
      do_op(1'b1, 1'b0, 32'h0000_0404, 32'h0, nstall, md);
      check("rd_stall_len", 64'(nstall), 64'(2 * W + 1));
      check("rd_mem_data", 64'(md), 64'(32'hDEAD_BEEF));
      check("rd_oe_cycles", 64'(rd_cycles), 64'(2 * W));
      check("rd_no_writes", 64'(wr_addr_q.size()), 64'(0));

      // Both enables: write wins, Mem_Data keeps the previous read
      clear_logs();
      do_op(1'b1, 1'b1, 32'h0000_0808, 32'h1234_5678, nstall, md);
      check("both_stall_len", 64'(nstall), 64'(2 * W + 1));
      check("both_mem_data", 64'(md), 64'(32'hDEAD_BEEF));
      check("both_beats", 64'(wr_addr_q.size()), 64'(2 * W));
      check("both_rd_cycles", 64'(rd_cycles), 64'(0));
      check("both_mem_lo", 64'(mem[10'h004]), 64'(16'h5678));
      check("both_mem_hi", 64'(mem[10'h005]), 64'(16'h1234));

      // Read the new word and confirm Mem_Data holds afterwards
      clear_logs();
      do_op(1'b1, 1'b0, 32'h0000_0808, 32'h0, nstall, md);
      check("rd2_mem_data", 64'(md), 64'(32'h1234_5678));
      repeat (3) @(posedge clk);
      #1;
      check("rd2_hold", 64'(Mem_Data), 64'(32'h1234_5678));
      check("idle_stall", 64'(stall), 64'(0));

`ifdef MEM_STAGE_STALL_CNT_EN
      cnt_before = stall_cnt;
      do_op(1'b1, 1'b0, 32'h0000_0404, 32'h0, nstall, md);
      do_op(1'b1, 1'b0, 32'h0000_0404, 32'h0, nstall, md);
      check("stall_cnt_delta", 64'(stall_cnt - cnt_before), 64'(2 * (2 * W + 1)));
`endif

      // Reset while the low half of a write is on the bus
      @(posedge clk);
      #1;
      MEM_W_En_in = 1'b1;
      ALU_result_in = 32'h0000_0404;
      ST_val_in = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      check("mid_we_active", 64'(SRAM_WE_N), 64'(0));
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_we_n", 64'(SRAM_WE_N), 64'(1));
      check("mid_rst_oe_n", 64'(SRAM_OE_N), 64'(1));
      check("mid_rst_dq_oe", 64'(SRAM_DQ_oe), 64'(0));
      check("mid_rst_mem_data", 64'(Mem_Data), 64'(0));
      check("mid_rst_stall_req", 64'(stall), 64'(1));
      MEM_W_En_in = 1'b0;
      #1;
      check("mid_rst_stall_idle", 64'(stall), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
      @(posedge clk);
      #1;
      check("post_rst_stall", 64'(stall), 64'(0));
      check("post_rst_we_n", 64'(SRAM_WE_N), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_no_retry", 64'(strobes), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 SHALL have parameter SRAM_WAIT, default 2, cycles per 16-bit SRAM half-access (legal 1..15).
REQ-002 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 WB_En_in, MEM_R_En_in, MEM_W_En_in  input  1 each  control bits from the EXE stage register.
REQ-006 dest_in  input  5  destination register; PC_in, ALU_result_in, ST_val_in  input  32 each.
REQ-007 WB_En, MEM_R_En  output  1 each; dest  output  5; PC, ALU_result  output  32 each; all pass-through to MEM_Stage_reg.
REQ-008 Mem_Data  output  32  assembled read word.
REQ-009 stall  output  1  freezes PC, IF/ID/EXE registers and MEM_Stage_reg while high.
REQ-010 SRAM_ADDR  output  18; SRAM_DQ_out  output  16; SRAM_DQ_in  input  16; SRAM_DQ_oe  output  1; SRAM_WE_N, SRAM_OE_N  output  1 each, active-low.

Function
REQ-011 Pass-through outputs SHALL equal their _in inputs combinationally, zero latency.
REQ-012 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-013 IDLE: if MEM_R_En_in or MEM_W_En_in, latch ALU_result_in[18:2] as word index, ST_val_in, and op type; go LOW; else stay.
REQ-014 LOW and HIGH SHALL each last exactly SRAM_WAIT cycles via a 4-bit wait counter; LOW->HIGH->DONE->IDLE.
REQ-015 SRAM_ADDR SHALL be {word_index, 1'b0} in LOW and {word_index, 1'b1} in HIGH; value in IDLE/DONE is don't-care.
REQ-016 Write: SRAM_WE_N=0, SRAM_DQ_oe=1 for every cycle of LOW/HIGH; SRAM_DQ_out = ST_val[15:0] in LOW, ST_val[31:16] in HIGH.
REQ-017 Read: SRAM_OE_N=0 in LOW/HIGH; SRAM_DQ_in sampled on the last cycle of LOW into Mem_Data[15:0] and of HIGH into Mem_Data[31:16].
REQ-018 Outside LOW/HIGH: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0.
REQ-019 stall SHALL be 1 in IDLE when a request is present, and in LOW and HIGH; 0 in DONE and in IDLE with no request.
REQ-020 Memory op latency: exactly 2*SRAM_WAIT+1 stall cycles, then one DONE cycle with stall=0 and Mem_Data valid.
REQ-021 MEM_R_En_in and MEM_W_En_in both high: write SHALL be performed, Mem_Data unchanged.
REQ-022 Mem_Data SHALL hold its value between reads; writes SHALL not modify it.
REQ-023 Inputs changing during LOW/HIGH SHALL not affect the access in flight (latched values used).

Reset
REQ-024 rst high SHALL asynchronously force state IDLE, wait counter 0, Mem_Data 0, latched address/data 0.
REQ-025 Reset mid-access SHALL immediately drive SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0; the access is abandoned, no retry.
REQ-026 During and after reset, stall SHALL depend only on IDLE rule (REQ-019).

Configuration
REQ-027 Macro MEM_STAGE_STALL_CNT_EN defined: output stall_cnt  32  counts cycles with stall=1, saturates at 32'hFFFFFFFF, reset to 0.
REQ-028 Macro undefined: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16.
REQ-030 SRAM sequencing (FSM, counter, SRAM pins, Mem_Data assembly) SHALL be sub-module sram_ctrl; mem_stage_sram adds pass-through and stall.

Verification
REQ-031 Reset mid-LOW of a write -> next cycle state IDLE, SRAM_WE_N=1, SRAM_DQ_oe=0, Mem_Data=0.
REQ-032 SRAM_WAIT=2, write ALU_result=32'h00000404, ST_val=32'hDEADBEEF -> SRAM_ADDR 18'h00202 with DQ 16'hBEEF 2 cycles, then 18'h00203 with 16'hDEAD 2 cycles; stall high 5 cycles.
REQ-033 Read same address, model returns stored halves -> Mem_Data=32'hDEADBEEF in DONE cycle, stall=0 that cycle.
REQ-034 Non-memory op (both enables 0) -> stall=0, no SRAM strobes, pass-through outputs equal inputs same cycle.
REQ-035 Both enables high with ST_val=32'h12345678 -> write performed, Mem_Data unchanged.
REQ-036 MEM_STAGE_STALL_CNT_EN defined, two back-to-back reads with SRAM_WAIT=1 -> stall_cnt=6.
